// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_pkg: shared widths and types for the register-file write path    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] xword_t;
endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter: round-robin, one-hot grant; pointer moves past each winner   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);
  localparam int c_PW = $clog2(N);

  logic [c_PW-1:0] r_ptr;
  logic [c_PW-1:0] w_ptr_nxt;

  function automatic logic [c_PW-1:0] wrap_add(input logic [c_PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return c_PW'(s);
  endfunction

  always_comb begin
    logic [c_PW-1:0] w_idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = wrap_add(r_ptr, k);
      if (!gnt_any && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
        gnt_any    = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = wrap_add(gnt_idx, 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (gnt_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end
endmodule
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_scheduler: arbitrates writebacks onto the single regfile      |
// | write port and keeps the busy scoreboard behind the issue stall.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      wb_valid,
  input  logic [NREQ*AW-1:0]   wb_rd,
  input  logic [NREQ*XLEN-1:0] wb_data,
  output logic [NREQ-1:0]      wb_ready,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rs1,
  input  logic [AW-1:0]        iss_rs2,
  input  logic                 iss_use_rs1,
  input  logic                 iss_use_rs2,
  input  logic [AW-1:0]        iss_rd,
  output logic                 iss_stall,
  output logic [AW-1:0]        rd,
  output logic                 RuWr,
  output logic [XLEN-1:0]      RuWrData
);
  logic [NREQ-1:0]         w_req;
  logic [NREQ-1:0]         w_gnt;
  logic [$clog2(NREQ)-1:0] w_gnt_idx;
  logic                    w_gnt_any;
  reg_idx_t                w_sel_rd;
  xword_t                  w_sel_data;
  logic                    w_issue;
  logic [NREG-1:0]         w_busy_nxt;

  reg_idx_t        r_rd;
  logic            r_wr;
  xword_t          r_data;
  logic [NREG-1:0] r_busy;

  // Grants are suppressed during reset so no transfer is accepted then.
  assign w_req = rst ? '0 : wb_valid;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  assign wb_ready = w_gnt;

  always_comb begin
    w_sel_rd   = wb_rd[int'(w_gnt_idx)*AW +: AW];
    w_sel_data = wb_data[int'(w_gnt_idx)*XLEN +: XLEN];
  end

  assign iss_stall = iss_valid &&
                     ((iss_use_rs1 && r_busy[iss_rs1]) ||
                      (iss_use_rs2 && r_busy[iss_rs2]) ||
                      ((iss_rd != '0) && r_busy[iss_rd]));

  assign w_issue = iss_valid && !iss_stall && (iss_rd != '0);

  // Set is applied after clear so a same-edge re-issue keeps the register pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_gnt_any) w_busy_nxt[w_sel_rd] = 1'b0;
    if (w_issue)   w_busy_nxt[iss_rd]   = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd   <= '0;
      r_wr   <= 1'b0;
      r_data <= '0;
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_gnt_any) begin
        r_rd   <= w_sel_rd;
        r_data <= w_sel_data;
        r_wr   <= (w_sel_rd != '0);
      end else begin
        r_wr   <= 1'b0;
      end
    end
  end

  assign rd       = r_rd;
  assign RuWr     = r_wr;
  assign RuWrData = r_data;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_scheduler: directed scenarios plus random traffic against  |
// | a cycle-level behavioural model of arbitration and the scoreboard.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_scheduler;
  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      wb_valid;
  logic [NREQ*AW-1:0]   wb_rd;
  logic [NREQ*XLEN-1:0] wb_data;
  logic [NREQ-1:0]      wb_ready;
  logic                 iss_valid, iss_use_rs1, iss_use_rs2;
  logic [AW-1:0]        iss_rs1, iss_rs2, iss_rd;
  logic                 iss_stall;
  logic [AW-1:0]        rd;
  logic                 RuWr;
  logic [XLEN-1:0]      RuWrData;

  regfile_wb_scheduler #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2), .iss_rd(iss_rd),
    .iss_stall(iss_stall), .rd(rd), .RuWr(RuWr), .RuWrData(RuWrData)
  );

  always #5 clk = ~clk;

  // Stand-in for registerunit: commits on the falling edge, x0 not protected here.
  logic [XLEN-1:0] tregs [32];
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) tregs[i] <= '0;
    end else if (RuWr) begin
      tregs[rd] <= RuWrData;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  int              mptr;
  logic [31:0]     mbusy;
  logic            m_wr;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_data;
  logic [NREQ-1:0] obs_ready;
  logic            obs_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (wb_valid[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic model_stall();
    return iss_valid && ((iss_use_rs1 && mbusy[iss_rs1]) ||
                         (iss_use_rs2 && mbusy[iss_rs2]) ||
                         (iss_rd != 0 && mbusy[iss_rd]));
  endfunction

  task automatic cycle();
    int              g;
    logic            s_stall, s_rst;
    logic [AW-1:0]   g_rd, s_ird;
    logic [XLEN-1:0] g_data;
    logic [NREQ-1:0] exp_r;
    @(negedge clk); #1;
    g       = model_grant();
    exp_r   = (g >= 0) ? NREQ'(1 << g) : '0;
    s_stall = model_stall();
    obs_ready = wb_ready;
    obs_stall = iss_stall;
    check("ready", wb_ready, exp_r);
    check("stall", iss_stall, s_stall);
    s_rst = rst;
    s_ird = iss_rd;
    g_rd   = (g >= 0) ? wb_rd[g*AW +: AW] : '0;
    g_data = (g >= 0) ? wb_data[g*XLEN +: XLEN] : '0;
    @(posedge clk);
    if (s_rst) begin
      mptr = 0; mbusy = '0; m_wr = 0; m_rd = '0; m_data = '0;
    end else begin
      if (g >= 0) begin
        mptr   = (g + 1) % NREQ;
        m_rd   = g_rd;
        m_data = g_data;
        m_wr   = (g_rd != 0);
        mbusy[g_rd] = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      if (iss_valid && !s_stall && s_ird != 0) mbusy[s_ird] = 1'b1;
      mbusy[0] = 1'b0;
    end
    #1;
    check("RuWr", RuWr, m_wr);
    check("rd", rd, m_rd);
    check("RuWrData", RuWrData, m_data);
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] r, input logic [XLEN-1:0] d);
    wb_valid[i]             = v;
    wb_rd[i*AW +: AW]       = r;
    wb_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic set_iss(input logic v, input logic [AW-1:0] r1, input logic u1,
                         input logic [AW-1:0] r2, input logic u2, input logic [AW-1:0] rdd);
    iss_valid = v; iss_rs1 = r1; iss_use_rs1 = u1;
    iss_rs2 = r2; iss_use_rs2 = u2; iss_rd = rdd;
  endtask

  // Reads busy[r] through the stall output without disturbing the scoreboard.
  task automatic probe(input string tag, input logic [AW-1:0] r, input logic exp);
    logic v, u1, u2;
    logic [AW-1:0] r1, r2, rdd;
    v = iss_valid; u1 = iss_use_rs1; u2 = iss_use_rs2; r1 = iss_rs1; r2 = iss_rs2; rdd = iss_rd;
    set_iss(1'b1, r, 1'b1, '0, 1'b0, '0);
    #1;
    check(tag, iss_stall, exp);
    set_iss(v, r1, u1, r2, u2, rdd);
    #1;
  endtask

  initial begin
    mptr = 0; mbusy = '0; m_wr = 0; m_rd = '0; m_data = '0;
    obs_ready = '0; obs_stall = 0;
    rst = 1'b1;
    wb_valid = '0; wb_rd = '0; wb_data = '0;
    set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0);

    set_req(0, 1'b1, 5'd5, 32'hA5A5_0005);
    set_req(1, 1'b1, 5'd6, 32'hB6B6_0006);
    cycle();
    check("rst_ready", obs_ready, 2'b00);
    check("rst_ruwr", RuWr, 1'b0);
    cycle();
    check("rst_ready2", obs_ready, 2'b00);
    rst = 1'b0;
    probe("rst_busy5", 5'd5, 1'b0);

    for (int k = 0; k < 4; k++) begin
      cycle();
      check("cont_gnt", obs_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("cont_ruwr", RuWr, 1'b1);
      check("cont_rd", rd, (k % 2 == 0) ? 5'd5 : 5'd6);
    end
    wb_valid = '0;
    cycle();

    set_iss(1'b1, '0, 1'b0, '0, 1'b0, 5'd7);
    cycle();
    set_iss(1'b1, 5'd7, 1'b1, '0, 1'b0, '0);
    cycle();
    check("haz_stall_a", obs_stall, 1'b1);
    cycle();
    check("haz_stall_b", obs_stall, 1'b1);
    set_req(0, 1'b1, 5'd7, 32'h1234_5678);
    cycle();
    check("haz_stall_at_wb", obs_stall, 1'b1);
    check("haz_wb_gnt", obs_ready, 2'b01);
    set_req(0, 1'b0, '0, '0);
    cycle();
    check("haz_release", obs_stall, 1'b0);
    check("haz_rf_x7", tregs[7], 32'h1234_5678);
    set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0);

    set_req(1, 1'b1, 5'd9, 32'h0000_0099);
    set_iss(1'b1, '0, 1'b0, '0, 1'b0, 5'd9);
    cycle();
    check("same_gnt", obs_ready, 2'b10);
    check("same_stall", obs_stall, 1'b0);
    set_req(1, 1'b0, '0, '0);
    set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0);
    probe("same_busy9", 5'd9, 1'b1);
    set_req(0, 1'b1, 5'd9, 32'h0000_0999);
    cycle();
    set_req(0, 1'b0, '0, '0);
    probe("busy9_cleared", 5'd9, 1'b0);

    set_req(1, 1'b1, 5'd0, 32'hDEAD_BEEF);
    cycle();
    check("x0_ready", obs_ready, 2'b10);
    check("x0_ruwr", RuWr, 1'b0);
    set_req(1, 1'b0, '0, '0);
    cycle();
    check("x0_reads0", tregs[0], 32'h0);

    set_req(0, 1'b1, 5'd3, 32'h3333_3333);
    set_iss(1'b1, '0, 1'b0, '0, 1'b0, 5'd3);
    cycle();
    check("mr_inflight", RuWr, 1'b1);
    set_req(0, 1'b0, '0, '0);
    set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    cycle();
    check("mr_ruwr", RuWr, 1'b0);
    rst = 1'b0;
    probe("mr_busy3", 5'd3, 1'b0);
    set_req(0, 1'b1, 5'd4, 32'h4444_4444);
    set_req(1, 1'b1, 5'd5, 32'h5555_5555);
    cycle();
    check("mr_ptr", obs_ready, 2'b01);
    wb_valid = '0;
    cycle();

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!wb_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, 5'($urandom_range(0, 7)), $urandom);
      end
      if (!(iss_valid && obs_stall))
        set_iss(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (obs_ready[i]) wb_valid[i] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
